aes_run_controller: RTL
=======================

Name: aes_run_controller

Overview:
- Parametrised successor to the AES top-level sequencer: one FSM drives any round-iterative AES core (encrypt or decrypt; 128/192/256-bit key) via start/step handshake, counts Nr rounds, captures the 128-bit result, and self-checks it against an expected block.
- Displays a selectable result byte (decimal or hex) on NUM_DIGITS seven-segment digits; optional auto-scan through all 16 bytes.
- Sits between board switches/buttons and the enc/dec core instances; key expansion stays in the core.

Parameters:
- NUM_DIGITS, 3, number of 7-seg digits driven (>=3)
- ROUND_GAP, 1, clk cycles between successive core_step pulses (>=1)
- SCAN_CYCLES, 50000000, clk cycles per byte in auto-scan (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE or SHOW
- mode  in  1  0=encrypt, 1=decrypt; latched at start
- key_type  in  2  00=128, 01=192, 10=256, 11=illegal; latched at start
- byte_sel  in  4  displayed byte index when auto_scan=0
- auto_scan  in  1  1=cycle displayed byte automatically
- disp_hex  in  1  1=two hex digits, 0=three decimal digits
- expected  in  128  reference block for self-check; latched at start
- core_result  in  128  core output, valid one cycle after the last core_step
- core_load  out  1  one-cycle pulse: core loads input block / round-0 AddRoundKey
- core_step  out  1  one-cycle pulse per round
- core_mode  out  1  latched mode
- core_key_type  out  2  latched key_type
- busy  out  1  high in LOAD, ROUND, CAPTURE
- done  out  1  one-cycle pulse on entry to SHOW
- match  out  1  captured result == latched expected
- err  out  1  sticky illegal-key flag
- round_cnt  out  4  rounds issued in the current run
- seg_out  out  7*NUM_DIGITS  active-low segments; digit d at [7d+6:7d] (d=0 least significant); bit0=a ... bit6=g

Behaviour:
- Reset: state IDLE. core_load=core_step=busy=done=match=err=0, round_cnt=0, result reg=0, scan index=0, seg_out all ones (blank). Reset wins over every other input in the same cycle; a reset mid-run abandons the run with no done.
- Nr = 10/12/14 for key_type 00/01/10.
- IDLE/SHOW + start:
  - key_type=11: set err, go to (or stay in) IDLE, no core pulses.
  - otherwise: clear err, match, round_cnt; latch mode, key_type, expected; go to LOAD.
- start while busy: ignored.
- LOAD (1 cycle): core_load=1 -> ROUND.
- ROUND: core_step pulses on the first ROUND cycle, then every ROUND_GAP cycles. round_cnt increments in the same cycle as each pulse. After the Nr-th pulse -> CAPTURE. No pulse follows the Nr-th.
- CAPTURE (1 cycle): register core_result; match <= (core_result == expected); -> SHOW with done=1 for one cycle.
- Latency with ROUND_GAP=1: start sampled at cycle 0 -> core_load at 1 -> steps at 2..Nr+1 -> capture at Nr+2 -> done at Nr+3.
- Byte k = result[8k+7:8k], i.e. byte 0 = last byte of the hex string.
- SHOW display:
  - auto_scan=0: displayed index = byte_sel.
  - auto_scan=1: the index advances every SCAN_CYCLES cycles, wraps 15->0, and resets to 0 on entering SHOW.
  - The display updates within 2 cycles of a byte_sel or disp_hex change.
- Decimal mode: double-dabble to 3 BCD digits. Leading zeros are blanked; digit 0 is always shown.
- Hex mode: digits 1..0 carry the high/low nibble, no blanking.
- Digits beyond those used are blank (7'b1111111). Outside SHOW all digits are blank.
- Encodings (g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- round_cnt, match, and the result register hold in SHOW until the next accepted start or reset.

Test Plan:
- Enc-128 with a core model returning 3ad77bb40d7a3660a89ecaf32466ef97, expected equal, ROUND_GAP=1 -> exactly 1 core_load and 10 core_step, done at cycle 13, match=1, byte_sel=0, decimal -> digits "151" (1111001,0010010,1111001).
- Same run, disp_hex=1 -> "97"; byte_sel=15 -> "3A"; byte_sel=1 decimal (0xef=239) -> "239"; byte 0x05 decimal -> digits 2,1 blank, digit 0 shows "5".
- Dec-256, ROUND_GAP=3, expected differs in one bit -> 14 steps spaced 3 cycles apart, round_cnt=14, done pulses, match=0.
- key_type=11 start -> err=1, no core_load/core_step, stays IDLE; a following legal start clears err.
- Reset asserted at round 5 of a 192-bit run -> next cycle IDLE, seg_out blank, no done; a new start afterwards runs a full 12 rounds.
- auto_scan=1, SCAN_CYCLES=4 -> displayed index steps 0,1,...,15,0 every 4 cycles; a start during ROUND is ignored (exactly one done).

Source files
------------

// File: rtl/aes_run_controller_if.sv
// Core-side handshake bundle for aes_run_controller.
//   core_load     : one-cycle pulse, core loads its input block / round-0 AddRoundKey
//   core_step     : one-cycle pulse per round
//   core_mode     : latched direction (0 = encrypt, 1 = decrypt)
//   core_key_type : latched key size (00 = 128, 01 = 192, 10 = 256)
//   core_result   : 128-bit core output, valid one cycle after the last core_step
// master = controller side, slave = AES core side.
interface aes_run_controller_if;
  logic         core_load;
  logic         core_step;
  logic         core_mode;
  logic [1:0]   core_key_type;
  logic [127:0] core_result;

  modport master (
    output core_load, core_step, core_mode, core_key_type,
    input  core_result
  );

  modport slave (
    input  core_load, core_step, core_mode, core_key_type,
    output core_result
  );
endinterface

// File: rtl/aes_run_controller.sv
// Run sequencer for a round-iterative AES core. Accepts a start request,
// pulses core_load once and core_step Nr times (10/12/14 for a 128/192/256-bit
// key), captures the core result, compares it with the latched expected
// block, and displays one result byte on seven-segment digits.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : run request, honoured only in IDLE or SHOW
//   mode, key_type        : run configuration, latched at start
//   byte_sel, auto_scan   : displayed byte index / automatic byte scan
//   disp_hex              : 1 = two hex digits, 0 = three decimal digits
//   expected              : reference block, latched at start
//   core                  : handshake bundle to the AES core (master side)
//   busy, done, match, err: run status
//   round_cnt             : rounds issued in the current run
//   seg_out               : active-low segments, digit d at [7d+6:7d], bit0 = a
module aes_run_controller #(
  parameter int unsigned NUM_DIGITS  = 3,
  parameter int unsigned ROUND_GAP   = 1,
  parameter int unsigned SCAN_CYCLES = 50000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic [1:0]                key_type,
  input  logic [3:0]                byte_sel,
  input  logic                      auto_scan,
  input  logic                      disp_hex,
  input  logic [127:0]              expected,
  aes_run_controller_if.master      core,
  output logic                      busy,
  output logic                      done,
  output logic                      match,
  output logic                      err,
  output logic [3:0]                round_cnt,
  output logic [7*NUM_DIGITS-1:0]   seg_out
);

  localparam int unsigned GAP_W  = (ROUND_GAP > 1) ? $clog2(ROUND_GAP) : 1;
  localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES);
  localparam logic [6:0]  BLANK  = 7'b1111111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_CAPTURE,
    S_SHOW
  } state_e;

  state_e                  state_q, state_d;
  logic                    mode_q;
  logic [1:0]              key_type_q;
  logic [127:0]            expected_q;
  logic [127:0]            result_q;
  logic                    match_q;
  logic                    err_q;
  logic                    done_q;
  logic [3:0]              round_cnt_q;
  logic [GAP_W-1:0]        gap_q;
  logic [3:0]              scan_idx_q;
  logic [SCAN_W-1:0]       scan_cnt_q;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;

  logic       accept;
  logic       step;
  logic       last_step;
  logic [3:0] nr;
  logic [3:0] disp_idx;
  logic [7:0] disp_byte;
  logic [11:0] bcd;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Double-dabble: add 3 to any BCD nibble >= 5 before each shift.
  function automatic logic [11:0] bin2bcd(input logic [7:0] b);
    logic [11:0] r;
    logic [7:0]  sh;
    r  = '0;
    sh = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[3:0]  >= 4'd5) r[3:0]  = r[3:0]  + 4'd3;
      if (r[7:4]  >= 4'd5) r[7:4]  = r[7:4]  + 4'd3;
      if (r[11:8] >= 4'd5) r[11:8] = r[11:8] + 4'd3;
      r  = {r[10:0], sh[7]};
      sh = {sh[6:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    case (key_type_q)
      2'b01:   nr = 4'd12;
      2'b10:   nr = 4'd14;
      default: nr = 4'd10;
    endcase
  end

  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_SHOW));
  assign step      = (state_q == S_ROUND) && (gap_q == '0);
  assign last_step = step && (round_cnt_q == nr - 4'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_SHOW: if (accept) state_d = (key_type == 2'b11) ? S_IDLE : S_LOAD;
      S_LOAD:         state_d = S_ROUND;
      S_ROUND:        if (last_step) state_d = S_CAPTURE;
      S_CAPTURE:      state_d = S_SHOW;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    disp_idx  = auto_scan ? scan_idx_q : byte_sel;
    disp_byte = result_q[{disp_idx, 3'b000} +: 8];
    bcd       = bin2bcd(disp_byte);
    seg_d     = '1;
    if (state_q == S_SHOW) begin
      if (disp_hex) begin
        seg_d[6:0]  = seg7(disp_byte[3:0]);
        seg_d[13:7] = seg7(disp_byte[7:4]);
      end else begin
        seg_d[6:0]   = seg7(bcd[3:0]);
        seg_d[13:7]  = (bcd[11:4] != '0) ? seg7(bcd[7:4]) : BLANK;
        seg_d[20:14] = (bcd[11:8] != '0) ? seg7(bcd[11:8]) : BLANK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 1'b0;
      key_type_q  <= '0;
      expected_q  <= '0;
      result_q    <= '0;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      round_cnt_q <= '0;
      gap_q       <= '0;
      scan_idx_q  <= '0;
      scan_cnt_q  <= '0;
      seg_q       <= '1;
    end else begin
      done_q <= (state_q == S_CAPTURE);
      seg_q  <= seg_d;

      if (accept) begin
        if (key_type == 2'b11) begin
          err_q <= 1'b1;
        end else begin
          err_q       <= 1'b0;
          match_q     <= 1'b0;
          round_cnt_q <= '0;
          mode_q      <= mode;
          key_type_q  <= key_type;
          expected_q  <= expected;
        end
      end

      // gap_q counts down between steps; a zero count in ROUND fires the next step.
      if (state_q == S_LOAD) begin
        gap_q <= '0;
      end else if (step) begin
        gap_q       <= GAP_W'(ROUND_GAP - 1);
        round_cnt_q <= round_cnt_q + 4'd1;
      end else if ((state_q == S_ROUND) && (gap_q != '0)) begin
        gap_q <= gap_q - GAP_W'(1);
      end

      if (state_q == S_CAPTURE) begin
        result_q <= core.core_result;
        match_q  <= (core.core_result == expected_q);
      end

      if ((state_d == S_SHOW) && (state_q != S_SHOW)) begin
        scan_idx_q <= '0;
        scan_cnt_q <= '0;
      end else if ((state_q == S_SHOW) && auto_scan) begin
        if (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1)) begin
          scan_cnt_q <= '0;
          scan_idx_q <= scan_idx_q + 4'd1;
        end else begin
          scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
        end
      end
    end
  end

  assign core.core_load     = (state_q == S_LOAD);
  assign core.core_step     = step;
  assign core.core_mode     = mode_q;
  assign core.core_key_type = key_type_q;

  assign busy      = (state_q == S_LOAD) || (state_q == S_ROUND) || (state_q == S_CAPTURE);
  assign done      = done_q;
  assign match     = match_q;
  assign err       = err_q;
  assign round_cnt = round_cnt_q;
  assign seg_out   = seg_q;

endmodule
